// File: rtl/split_cand_gen.sv
// split_cand_gen: LFSR-driven candidate assignment generator for the split_* constraint checkers
module split_cand_gen #(
  parameter int          MAX_TRIES = 1024,
  parameter int          CNT_W     = 16,
  parameter logic [63:0] TAPS      = 64'hD800000000000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [63:0]      seed,
  output logic             cand_valid,
  input  logic             cand_ready,
  output logic [35:0]      var_0,
  output logic [50:0]      var_1,
  output logic [56:0]      var_2,
  output logic [53:0]      var_3,
  output logic [59:0]      var_4,
  output logic [48:0]      var_5,
  output logic [38:0]      var_6,
  output logic [56:0]      var_7,
  output logic [56:0]      var_8,
  output logic [45:0]      var_9,
  input  logic             res_valid,
  input  logic             res_sat,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [CNT_W-1:0] tries
);
  typedef enum logic [2:0] {IDLE, FILL, OFFER, WAIT, FIN} state_t;
  localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_TRIES);
  state_t           state_q, state_d;
  logic [63:0]      lfsr_q, lfsr_d, step;
  logic [447:0]     buf_q, buf_d;
  logic [505:0]     pool_q, pool_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] tries_q, tries_d, tries_inc;
  logic             found_q, found_d, hs, decide;
  // Next-state logic: FILL collects eight LFSR words, OFFER/WAIT run the handshake and verdict
  always_comb begin
    step      = lfsr_q[0] ? (lfsr_q >> 1) ^ TAPS : lfsr_q >> 1;
    tries_inc = tries_q == MAX ? tries_q : tries_q + CNT_W'(1);
    hs        = state_q == OFFER && cand_ready;
    decide    = (hs || state_q == WAIT) && res_valid;
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    buf_d     = buf_q;
    pool_d    = pool_q;
    cnt_d     = cnt_q;
    tries_d   = hs ? tries_inc : tries_q;
    found_d   = found_q;
    case (state_q)
      IDLE: if (start) begin
        lfsr_d  = seed == '0 ? 64'h1 : seed;
        tries_d = '0;
        found_d = 1'b0;
        cnt_d   = '0;
        state_d = FILL;
      end
      FILL: begin
        lfsr_d = step;
        buf_d  = {step, buf_q[447:64]};
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          pool_d  = {step[57:0], buf_q};
          state_d = OFFER;
        end
      end
      OFFER: if (hs) state_d = WAIT;
      FIN:   state_d = IDLE;
      default: ;
    endcase
    if (decide) begin
      found_d = res_sat;
      state_d = (res_sat || tries_d == MAX) ? FIN : FILL;
    end
  end
  // State registers with synchronous reset to an idle, all-zero output state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= 64'h1;
      buf_q   <= '0;
      pool_q  <= '0;
      cnt_q   <= '0;
      tries_q <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      buf_q   <= buf_d;
      pool_q  <= pool_d;
      cnt_q   <= cnt_d;
      tries_q <= tries_d;
      found_q <= found_d;
    end
  end
  assign cand_valid = state_q == OFFER;
  assign busy       = state_q != IDLE;
  assign done       = state_q == FIN;
  assign found      = found_q;
  assign tries      = tries_q;
  assign var_0      = pool_q[35:0];
  assign var_1      = pool_q[86:36];
  assign var_2      = pool_q[143:87];
  assign var_3      = pool_q[197:144];
  assign var_4      = pool_q[257:198];
  assign var_5      = pool_q[306:258];
  assign var_6      = pool_q[345:307];
  assign var_7      = pool_q[402:346];
  assign var_8      = pool_q[459:403];
  assign var_9      = pool_q[505:460];
endmodule

// File: tb/tb_split_cand_gen.sv
// tb_split_cand_gen: directed self-checking bench for split_cand_gen
module tb_split_cand_gen;
  localparam logic [63:0] TAPS = 64'hD800000000000000;
  logic clk = 0, rst = 0, start = 0, cand_ready = 0, res_valid = 0, res_sat = 0;
  logic [63:0] seed = '0;
  logic cand_valid, busy, done, found;
  logic [15:0] tries;
  logic [35:0] var_0;
  logic [50:0] var_1;
  logic [56:0] var_2;
  logic [53:0] var_3;
  logic [59:0] var_4;
  logic [48:0] var_5;
  logic [38:0] var_6;
  logic [56:0] var_7;
  logic [56:0] var_8;
  logic [45:0] var_9;
  logic [505:0] vcat, p, snap;
  logic [505:0] pools [4];
  logic [63:0] ms;
  int passed = 0, total = 0;
  assign vcat = {var_9, var_8, var_7, var_6, var_5, var_4, var_3, var_2, var_1, var_0};
  split_cand_gen #(.MAX_TRIES(4), .CNT_W(16), .TAPS(TAPS)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .cand_valid(cand_valid),
    .cand_ready(cand_ready), .var_0(var_0), .var_1(var_1), .var_2(var_2), .var_3(var_3),
    .var_4(var_4), .var_5(var_5), .var_6(var_6), .var_7(var_7), .var_8(var_8), .var_9(var_9),
    .res_valid(res_valid), .res_sat(res_sat), .busy(busy), .done(done), .found(found), .tries(tries)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic mgen(output logic [505:0] q);
    logic [511:0] t;
    for (int k = 0; k < 8; k++) begin
      ms = ms[0] ? (ms >> 1) ^ TAPS : ms >> 1;
      t[k*64 +: 64] = ms;
    end
    q = t[505:0];
  endtask
  task automatic go(input logic [63:0] s);
    seed = s;
    start = 1;
    tick;
    start = 0;
  endtask
  task automatic wait_cv(input string tag);
    int n = 0;
    while (!cand_valid && n < 12) begin
      tick;
      n++;
    end
    chk(tag, cand_valid, 1);
  endtask
  task automatic hs(input int lat, input bit sat);
    cand_ready = 1;
    if (lat == 0) begin
      res_valid = 1;
      res_sat = sat;
    end
    tick;
    cand_ready = 0;
    res_valid = 0;
    if (lat > 0) begin
      repeat (lat - 1) tick;
      res_valid = 1;
      res_sat = sat;
      tick;
      res_valid = 0;
    end
  endtask
  initial begin
    rst = 1;
    tick;
    tick;
    rst = 0;
    chk("rst_cand_valid", cand_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_tries", tries, 0);
    chk("rst_vars", vcat, 0);
    go(64'h1);
    for (int c = 1; c <= 8; c++) begin
      chk("t1_fill_cand_valid", cand_valid, 0);
      chk("t1_fill_busy", busy, 1);
      tick;
    end
    chk("t1_cycle9_cand_valid", cand_valid, 1);
    chk("t1_var_0", var_0, 36'h0);
    chk("t1_var_1", var_1, 51'hD800000);
    chk("t1_var_9", var_9, 46'h1B0000000000);
    ms = 64'h1;
    mgen(p);
    chk("t1_pool", vcat, p);
    hs(0, 1);
    chk("t1_done", done, 1);
    chk("t1_found", found, 1);
    chk("t1_tries", tries, 1);
    chk("t1_cand_valid_low", cand_valid, 0);
    chk("t1_busy_fin", busy, 1);
    tick;
    chk("t1_done_pulse", done, 0);
    chk("t1_idle", busy, 0);
    chk("t1_found_hold", found, 1);
    ms = 64'h0123456789ABCDEF;
    go(ms);
    for (int i = 0; i < 4; i++) begin
      wait_cv("t2_wait_cand");
      mgen(p);
      chk("t2_pool", vcat, p);
      pools[i] = vcat;
      hs(1, 0);
      chk("t2_tries", tries, i + 1);
      chk("t2_done", done, i == 3);
    end
    chk("t2_found", found, 0);
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        chk("t2_distinct", pools[i] != pools[j], 1);
    tick;
    chk("t2_idle", busy, 0);
    chk("t2_no_more_cand", cand_valid, 0);
    ms = 64'h0F0F_1234_5678_9ABC;
    go(ms);
    wait_cv("t3_wait_cand");
    mgen(p);
    snap = vcat;
    chk("t3_pool", vcat, p);
    for (int c = 0; c < 5; c++) begin
      tick;
      chk("t3_bp_cand_valid", cand_valid, 1);
      chk("t3_bp_vars", vcat, snap);
      chk("t3_bp_tries", tries, 0);
    end
    hs(0, 1);
    chk("t3_done", done, 1);
    chk("t3_tries", tries, 1);
    chk("t3_found", found, 1);
    tick;
    ms = 64'h1;
    go(64'h0);
    wait_cv("t4_wait_cand0");
    mgen(p);
    chk("t4_pool0", vcat, p);
    hs(0, 0);
    chk("t4_not_done", done, 0);
    wait_cv("t4_wait_cand1");
    mgen(p);
    chk("t4_pool1", vcat, p);
    hs(2, 1);
    chk("t4_done", done, 1);
    chk("t4_found", found, 1);
    chk("t4_tries", tries, 2);
    tick;
    go(64'h5);
    wait_cv("t5_wait_cand");
    cand_ready = 1;
    tick;
    cand_ready = 0;
    chk("t5_in_wait", busy, 1);
    rst = 1;
    tick;
    rst = 0;
    chk("t5_rst_cand_valid", cand_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_found", found, 0);
    chk("t5_rst_tries", tries, 0);
    chk("t5_rst_vars", vcat, 0);
    res_valid = 1;
    res_sat = 1;
    tick;
    res_valid = 0;
    for (int c = 0; c < 3; c++) begin
      chk("t5_stray_done", done, 0);
      chk("t5_stray_busy", busy, 0);
      tick;
    end
    go(64'h1);
    wait_cv("t5_wait_cand_new");
    chk("t5_var_1", var_1, 51'hD800000);
    hs(0, 1);
    chk("t5_done", done, 1);
    chk("t5_tries", tries, 1);
    tick;
    ms = 64'hCAFEF00D12345678;
    go(ms);
    tick;
    tick;
    start = 1;
    seed = 64'hFFFF;
    res_valid = 1;
    res_sat = 1;
    tick;
    start = 0;
    res_valid = 0;
    chk("t6_tries_unchanged", tries, 0);
    chk("t6_busy", busy, 1);
    wait_cv("t6_wait_cand0");
    mgen(p);
    chk("t6_pool0", vcat, p);
    hs(0, 0);
    tick;
    res_valid = 1;
    res_sat = 1;
    tick;
    res_valid = 0;
    chk("t6_tries_mid", tries, 1);
    chk("t6_no_done", done, 0);
    wait_cv("t6_wait_cand1");
    mgen(p);
    chk("t6_pool1", vcat, p);
    hs(0, 1);
    chk("t6_done", done, 1);
    chk("t6_found", found, 1);
    chk("t6_tries", tries, 2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/split_cand_gen.md
# split_cand_gen

Candidate-assignment generator that drives the ten-variable constraint checkers (`split_*`) from the transmit side. On `start` it seeds a 64-bit LFSR and builds pseudo-random assignments for `var_0`..`var_9`. It offers each assignment to the checker over a valid/ready handshake, then waits for the checker's verdict. It stops at the first satisfying assignment or after `MAX_TRIES` candidates, and holds the winning assignment and the try count for the solver controller.

## Interface
- `MAX_TRIES`, 1024: candidates tried before giving up; range 1..2^CNT_W-1.
- `CNT_W`, 16: width of the try counter.
- `TAPS`, 64'hD800000000000000: Galois LFSR feedback mask (x^64+x^63+x^61+x^60+1).

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a search; ignored unless idle.
- `seed`  in  64  LFSR seed, sampled with `start`.
- `cand_valid`  out  1  candidate on `var_*` is offered.
- `cand_ready`  in  1  checker accepts the candidate.
- `var_0`..`var_9`  out  36/51/57/54/60/49/39/57/57/46  candidate assignment.
- `res_valid`  in  1  checker verdict strobe.
- `res_sat`  in  1  verdict; 1 = all constraints hold (checker `x`).
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at the end of a search.
- `found`  out  1  last search ended with a satisfying candidate.
- `tries`  out  CNT_W  candidates accepted by the checker in the last or current search.

## Operation
- **States:** IDLE, FILL, OFFER, WAIT, FIN.
- **IDLE**
  - `start` loads the LFSR with `seed`. A zero seed is replaced by 64'h1.
  - Clears `tries` and `found`, then goes to FILL.
- **FILL:** exactly 8 cycles.
  - Each cycle advances the LFSR one step. A step is: if lsb is 1, state = (state>>1)^TAPS; otherwise state = state>>1.
  - Word Wk is the state after step k+1, k = 0..7.
  - The pool is {W7,...,W0}, 512 bits, with W0 in bits 63:0.
- **Slicing** of the pool onto the outputs:
  - `var_0`=pool[35:0], `var_1`=[86:36], `var_2`=[143:87], `var_3`=[197:144], `var_4`=[257:198].
  - `var_5`=[306:258], `var_6`=[345:307], `var_7`=[402:346], `var_8`=[459:403], `var_9`=[505:460].
  - Bits 511:506 are discarded.
- `var_*` update only when FILL completes. They are stable at all other times.
- The LFSR continues from its current state for later candidates; it is never reseeded mid-search.
- **OFFER:** `cand_valid`=1 until `cand_valid&&cand_ready`. On that handshake `tries` increments and the FSM goes to WAIT.
- **WAIT:** `res_valid` may arrive in the handshake cycle or any later cycle. Only one candidate is outstanding.
  - A `res_valid` seen in the handshake cycle is consumed and WAIT is skipped.
  - `res_sat`=1: `found`=1, go to FIN.
  - `res_sat`=0 and `tries`==MAX_TRIES: go to FIN with `found`=0.
  - Otherwise go to FILL.
- **FIN:** `done`=1 for one cycle, then IDLE.
  - `found`, `tries` and `var_*` hold until the next accepted `start`.
- **Ignored inputs:**
  - `res_valid` outside OFFER-handshake/WAIT.
  - `cand_ready` outside OFFER.
  - `start` outside IDLE.
- **Reset:**
  - All outputs go to 0, the LFSR to 64'h1, and the FSM to IDLE.
  - Reset mid-search abandons it; a later `res_valid` for the abandoned candidate is ignored.

## Timing
- `start` is sampled at edge 0. FILL occupies cycles 1..8. `cand_valid` is first high in cycle 9.
- `busy` is high from cycle 1 through the FIN cycle. `done` coincides with the last `busy` cycle.
- Minimum per-candidate period with zero-latency ready/verdict: 9 cycles (8 FILL + 1 OFFER).
- `done` asserts the cycle after the deciding `res_valid`.
- `tries` saturates at MAX_TRIES and never wraps.

## Test plan
1. **First candidate satisfies.**
   - Stimulus: `seed`=1; `cand_ready`=1; `res_valid`=`res_sat`=1 in the handshake cycle.
   - Response: `cand_valid` high in cycle 9 only.
   - W0=64'hD800000000000000, so `var_0`=36'h0 and `var_1`[27:0]=28'hD800000.
   - `done` in cycle 10 with `found`=1 and `tries`=1.
2. **Exhaustion.**
   - Stimulus: MAX_TRIES=4; checker always returns `res_sat`=0 one cycle after the handshake.
   - Response: exactly 4 handshakes, then `done` with `found`=0 and `tries`=4.
   - The four candidates are pairwise distinct.
3. **Backpressure.**
   - Stimulus: `cand_ready` low for 5 cycles after `cand_valid` rises.
   - Response: `cand_valid` and all `var_*` stay constant for those cycles; `tries` increments only on the handshake.
4. **Zero seed.**
   - Stimulus: `seed`=0.
   - Response: the candidate sequence is bit-identical to a `seed`=1 run.
5. **Reset mid-WAIT.**
   - Stimulus: `rst` pulsed while in WAIT, then a stray `res_valid`=1/`res_sat`=1.
   - Response: all outputs 0, `done` never pulses, and a new `start` behaves as in test 1.
6. **Ignored inputs.**
   - Stimulus: `start` asserted while `busy`; `res_valid` pulsed during FILL.
   - Response: no reseed, no change to `tries`, and the search completes as without the stray pulses.
